// File: rtl/video_timing_receiver.sv
// video_timing_receiver: samples a parallel video bus in the clk domain, recovers active-area pixel
// positions, measures line/frame timing and reports lock after consecutive identical frames.
module video_timing_receiver #(
    parameter bit HSYNC_POL    = 1'b1,
    parameter bit VSYNC_POL    = 1'b1,
    parameter int LOCK_FRAMES  = 2,
    parameter int TIMEOUT_CLKS = 4000000
) (
    input  logic        clk,
    input  logic        sys_rst_n,
    input  logic        i_adv_clk,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic        i_de,
    input  logic [7:0]  i_r,
    input  logic [7:0]  i_g,
    input  logic [7:0]  i_b,
    output logic        o_valid,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic [7:0]  o_r,
    output logic [7:0]  o_g,
    output logic [7:0]  o_b,
    output logic        o_frame,
    output logic [11:0] o_h_total,
    output logic [11:0] o_h_active,
    output logic [11:0] o_v_total,
    output logic [11:0] o_v_active,
    output logic        o_locked,
    output logic        o_unlock
);
    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;
    localparam logic [11:0] MAX = 12'hfff;

    state_t      state_q, state_d;
    logic        adv_clk_q, adv_clk_d, hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic        line_de_q, line_de_d, frame_de_q, frame_de_d, ovf_q, ovf_d;
    logic        valid_q, valid_d, frame_q, frame_d, unlock_q, unlock_d;
    logic [11:0] h_cnt_q, h_cnt_d, de_cnt_q, de_cnt_d, line_cnt_q, line_cnt_d, act_cnt_q, act_cnt_d;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic [11:0] h_total_q, h_total_d, h_active_q, h_active_d, v_total_q, v_total_d, v_active_q, v_active_d;
    logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic [47:0] ref_q, ref_d, totals;
    logic [3:0]  match_q, match_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        pix, de, hs_edge, vs_edge, line_de_eff, frame_de_eff, first, timeout, match_ok, reload;
    logic [11:0] line_nxt, act_nxt;

    always_comb begin
        adv_clk_d    = i_adv_clk;
        pix          = i_adv_clk & ~adv_clk_q;
        de           = pix & i_de;
        hs_edge      = pix & (i_hsync == HSYNC_POL) & ~hs_prev_q;
        vs_edge      = pix & (i_vsync == VSYNC_POL) & ~vs_prev_q;
        hs_prev_d    = pix ? (i_hsync == HSYNC_POL) : hs_prev_q;
        vs_prev_d    = pix ? (i_vsync == VSYNC_POL) : vs_prev_q;
        timeout      = to_cnt_q == 32'(TIMEOUT_CLKS - 1);
        to_cnt_d     = (vs_edge | timeout) ? '0 : to_cnt_q + 32'd1;
        h_cnt_d      = hs_edge ? '0 : (pix && h_cnt_q != MAX) ? h_cnt_q + 12'd1 : h_cnt_q;
        de_cnt_d     = hs_edge ? {11'd0, i_de} : (de && de_cnt_q != MAX) ? de_cnt_q + 12'd1 : de_cnt_q;
        ovf_d        = ~vs_edge & (ovf_q | (pix & ~hs_edge & h_cnt_q == MAX) | (de & ~hs_edge & de_cnt_q == MAX));
        line_nxt     = (hs_edge && line_cnt_q != MAX) ? line_cnt_q + 12'd1 : line_cnt_q;
        act_nxt      = (hs_edge && line_de_q && act_cnt_q != MAX) ? act_cnt_q + 12'd1 : act_cnt_q;
        line_cnt_d   = vs_edge ? '0 : line_nxt;
        act_cnt_d    = vs_edge ? '0 : act_nxt;
        h_total_d    = timeout ? '0 : hs_edge ? h_cnt_q + 12'd1 : h_total_q;
        // blanking lines leave h_active alone so it keeps the width of the last active line
        h_active_d   = timeout ? '0 : (hs_edge & line_de_q) ? de_cnt_q : h_active_q;
        v_total_d    = timeout ? '0 : vs_edge ? line_nxt : v_total_q;
        v_active_d   = timeout ? '0 : vs_edge ? act_nxt : v_active_q;
        line_de_eff  = line_de_q & ~hs_edge;
        frame_de_eff = frame_de_q & ~vs_edge;
        first        = ~line_de_eff;
        line_de_d    = line_de_eff | de;
        frame_de_d   = frame_de_eff | de;
        x_d          = !de ? x_q : first ? '0 : (x_q == MAX) ? x_q : x_q + 12'd1;
        y_d          = !(de & first) ? y_q : frame_de_eff ? y_q + 12'd1 : '0;
        valid_d      = de;
        frame_d      = vs_edge;
        r_d          = de ? i_r : r_q;
        g_d          = de ? i_g : g_q;
        b_d          = de ? i_b : b_q;
        totals       = {h_total_d, h_active_d, v_total_d, v_active_d};
        match_ok     = totals == ref_q && !ovf_q;
    end

    always_comb begin
        state_d = state_q;
        if (timeout)
            state_d = SEARCH;
        else if (vs_edge)
            case (state_q)
                SEARCH:  state_d = MEASURE;
                MEASURE: state_d = VERIFY;
                VERIFY:  state_d = (match_ok && match_q + 4'd1 == 4'(LOCK_FRAMES)) ? LOCKED : VERIFY;
                default: state_d = match_ok ? LOCKED : VERIFY;
            endcase
    end

    always_comb begin
        reload   = vs_edge & ~timeout & (state_q == MEASURE || (state_q != SEARCH && !match_ok));
        ref_d    = reload ? totals : ref_q;
        match_d  = (timeout || reload) ? '0 : (vs_edge && state_q == VERIFY) ? match_q + 4'd1 : match_q;
        unlock_d = (state_q == LOCKED) & (timeout | (vs_edge & ~match_ok));
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n)
            state_q <= SEARCH;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            {adv_clk_q, hs_prev_q, vs_prev_q, line_de_q, frame_de_q, ovf_q} <= '0;
            {valid_q, frame_q, unlock_q} <= '0;
            {h_cnt_q, de_cnt_q, line_cnt_q, act_cnt_q, x_q, y_q} <= '0;
            {h_total_q, h_active_q, v_total_q, v_active_q} <= '0;
            {r_q, g_q, b_q} <= '0;
            ref_q    <= '0;
            match_q  <= '0;
            to_cnt_q <= '0;
        end else begin
            {adv_clk_q, hs_prev_q, vs_prev_q, line_de_q, frame_de_q, ovf_q} <=
                {adv_clk_d, hs_prev_d, vs_prev_d, line_de_d, frame_de_d, ovf_d};
            {valid_q, frame_q, unlock_q} <= {valid_d, frame_d, unlock_d};
            {h_cnt_q, de_cnt_q, line_cnt_q, act_cnt_q, x_q, y_q} <=
                {h_cnt_d, de_cnt_d, line_cnt_d, act_cnt_d, x_d, y_d};
            {h_total_q, h_active_q, v_total_q, v_active_q} <= {h_total_d, h_active_d, v_total_d, v_active_d};
            {r_q, g_q, b_q} <= {r_d, g_d, b_d};
            ref_q    <= ref_d;
            match_q  <= match_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_x        = x_q;
    assign o_y        = y_q;
    assign o_r        = r_q;
    assign o_g        = g_q;
    assign o_b        = b_q;
    assign o_frame    = frame_q;
    assign o_h_total  = h_total_q;
    assign o_h_active = h_active_q;
    assign o_v_total  = v_total_q;
    assign o_v_active = v_active_q;
    assign o_locked   = state_q == LOCKED;
    assign o_unlock   = unlock_q;
endmodule
